// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Serves single-word hits combinationally; on a miss it stalls the pipeline,
// writes back a dirty victim, refills the line and then completes the held request.
module dcache_controller #(
    parameter int unsigned LINES     = 16,
    parameter int unsigned LINE_BITS = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned OFF_W  = $clog2(LINE_BITS / 8);
    localparam int unsigned WSEL_W = $clog2(LINE_BITS / 32);
    localparam int unsigned TAG_W  = 32 - IDX_W - OFF_W;

    typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

    state_e state_q, state_d;

    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     dirty_q;
    logic [TAG_W-1:0]     tag_q  [LINES];
    logic [LINE_BITS-1:0] data_q [LINES];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  req_tag;
    logic [WSEL_W-1:0] wsel;
    logic              hit;
    logic              store_hit;
    logic              refill;
    logic              unused_addr;

    assign idx         = cpu_addr_i[OFF_W +: IDX_W];
    assign req_tag     = cpu_addr_i[31 -: TAG_W];
    assign wsel        = cpu_addr_i[2 +: WSEL_W];
    assign unused_addr = ^cpu_addr_i[1:0];

    // Outside IDLE the indexed line never matches the request tag, so hit is state-independent.
    assign hit       = cpu_req_i & valid_q[idx] & (tag_q[idx] == req_tag);
    assign store_hit = (state_q == StIdle) & hit & cpu_we_i;
    assign refill    = (state_q == StAllocate) & mem_ack_i;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Line status bits: set valid on refill, mark dirty on store hits.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (refill) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (store_hit) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag and data arrays: refill the whole line or merge one store word.
    always_ff @(posedge clk_i) begin
        if (refill) begin
            data_q[idx] <= mem_data_i;
            tag_q[idx]  <= req_tag;
        end else if (store_hit) begin
            data_q[idx][32*wsel +: 32] <= cpu_data_i;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_req_i && !hit) begin
                    state_d = (valid_q[idx] && dirty_q[idx]) ? StWriteback : StAllocate;
                end
            end
            StWriteback: if (mem_ack_i) state_d = StAllocate;
            StAllocate:  if (mem_ack_i) state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    // Outputs: CPU stall/data and memory transaction signals decoded from state.
    always_comb begin
        cpu_data_o   = hit ? data_q[idx][32*wsel +: 32] : 32'h0;
        cpu_stall_o  = (state_q != StIdle) | (cpu_req_i & ~hit);
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = 32'h0;
        mem_data_o   = '0;
        unique case (state_q)
            StWriteback: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_q[idx], idx, {OFF_W{1'b0}}};
                mem_data_o   = data_q[idx];
            end
            StAllocate: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {req_tag, idx, {OFF_W{1'b0}}};
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: directed requests push expected CPU
// completions and memory transactions; a negedge monitor pops and compares.
module tb_dcache_controller;
    localparam int MEM_LAT = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpu_req = 1'b0;
    logic         cpu_we = 1'b0;
    logic [31:0]  cpu_addr = 32'h0;
    logic [31:0]  cpu_wdata = 32'h0;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_rdata = '0;
    logic         mem_ack_m = 1'b0;
    logic         stray_ack = 1'b0;
    logic         mem_ack_i;

    assign mem_ack_i = mem_ack_m | stray_ack;

    always #5 clk = ~clk;

    dcache_controller #(.LINES(16), .LINE_BITS(256)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .cpu_req_i   (cpu_req),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_data_i  (cpu_wdata),
        .cpu_data_o  (cpu_data_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_enable_o(mem_enable_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_rdata),
        .mem_ack_i   (mem_ack_i)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] data;
        int          stalls;
        int          ens;
    } cpu_exp_t;

    typedef struct {
        string       name;
        logic        write;
        logic [31:0] addr;
        logic        chk_word;
        int          word;
        logic [31:0] wdata;
    } mem_exp_t;

    cpu_exp_t cpuq[$];
    mem_exp_t memq[$];
    logic [255:0] mem_store [logic [31:0]];

    int n_vec = 0;
    int n_fail = 0;
    int stall_cnt = 0;
    int en_cnt = 0;
    int mcnt = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Backing store: unwritten lines hold an address-derived pattern.
    function automatic logic [255:0] get_line(logic [31:0] a);
        logic [255:0] l;
        if (mem_store.exists(a)) return mem_store[a];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'hC000_0000 | (a + 32'(4 * w));
        return l;
    endfunction

    // Memory model: ack in the MEM_LAT-th cycle of mem_enable_o.
    always begin
        @(posedge clk);
        #1;
        if (!mem_enable_o) begin
            mcnt      = 0;
            mem_ack_m = 1'b0;
            mem_rdata = '0;
        end else begin
            mcnt      = mem_ack_m ? 1 : mcnt + 1;
            mem_ack_m = (mcnt == MEM_LAT);
            mem_rdata = mem_ack_m ? get_line(mem_addr_o) : '0;
        end
    end

    // Monitor: compare memory transactions on ack and CPU requests on completion.
    always @(negedge clk) begin
        mem_exp_t me;
        cpu_exp_t ce;
        if (!rst_n) begin
            stall_cnt = 0;
            en_cnt    = 0;
        end else begin
            if (mem_enable_o) begin
                en_cnt++;
                if (mem_ack_i) begin
                    if (memq.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL mem_unexpected: got addr %h write %b expected none",
                                 mem_addr_o, mem_write_o);
                    end else begin
                        me = memq.pop_front();
                        chk({me.name, "_write"}, {31'b0, mem_write_o}, {31'b0, me.write});
                        chk({me.name, "_addr"}, mem_addr_o, me.addr);
                        if (me.chk_word) chk({me.name, "_word"}, mem_data_o[me.word*32 +: 32], me.wdata);
                    end
                    if (mem_write_o) mem_store[mem_addr_o] = mem_data_o;
                end
            end
            if (cpu_req) begin
                if (cpu_stall_o) begin
                    stall_cnt++;
                end else if (cpuq.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL cpu_unexpected: got completion at %h expected none", cpu_addr);
                end else begin
                    ce = cpuq.pop_front();
                    chk({ce.name, "_stalls"}, 32'(stall_cnt), 32'(ce.stalls));
                    chk({ce.name, "_mem_cycles"}, 32'(en_cnt), 32'(ce.ens));
                    if (!ce.we) chk({ce.name, "_data"}, cpu_data_o, ce.data);
                    stall_cnt = 0;
                    en_cnt    = 0;
                end
            end
        end
    end

    task automatic expect_mem(string name, logic write, logic [31:0] addr, logic chk_word,
                              int word, logic [31:0] wdata);
        mem_exp_t e;
        e.name = name; e.write = write; e.addr = addr;
        e.chk_word = chk_word; e.word = word; e.wdata = wdata;
        memq.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the completing edge.
    task automatic issue(string name, logic we, logic [31:0] addr, logic [31:0] wdata,
                         logic [31:0] exp, int stalls, int ens);
        cpu_exp_t e;
        bit done = 0;
        e.name = name; e.we = we; e.data = exp; e.stalls = stalls; e.ens = ens;
        cpuq.push_back(e);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!cpu_stall_o) done = 1;
        end
        if (!done) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s_timeout: got stall after 40 cycles expected completion", name);
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    initial begin
        logic [255:0] l40;
        l40 = get_line(32'h40);
        l40[31:0] = 32'hA5A5_0000;
        mem_store[32'h40] = l40;

        // Reset state.
        #12;
        chk("rst_stall_idle", {31'b0, cpu_stall_o}, 32'h0);
        chk("rst_enable", {31'b0, mem_enable_o}, 32'h0);
        chk("rst_write", {31'b0, mem_write_o}, 32'h0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_mdata", mem_data_o[31:0] | mem_data_o[255:224], 32'h0);
        chk("rst_cdata", cpu_data_o, 32'h0);
        cpu_req = 1'b1; cpu_addr = 32'h40;
        #1;
        chk("rst_stall_req", {31'b0, cpu_stall_o}, 32'h1);
        cpu_req = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // Read miss, store hit, load hit.
        expect_mem("t1_rd", 1'b0, 32'h40, 1'b0, 0, 32'h0);
        issue("t1_load40", 1'b0, 32'h40, 32'h0, 32'hA5A5_0000, 4, 3);
        issue("t2_store44", 1'b1, 32'h44, 32'hDEAD_BEEF, 32'h0, 0, 0);
        issue("t3_load44", 1'b0, 32'h44, 32'h0, 32'hDEAD_BEEF, 0, 0);

        // Dirty eviction.
        expect_mem("t4_wb", 1'b1, 32'h40, 1'b1, 1, 32'hDEAD_BEEF);
        expect_mem("t4_rd", 1'b0, 32'h240, 1'b0, 0, 32'h0);
        issue("t4_load240", 1'b0, 32'h240, 32'h0, 32'hC000_0240, 7, 6);

        // Store miss, then eviction of the merged line.
        expect_mem("t5_rd", 1'b0, 32'h1000, 1'b0, 0, 32'h0);
        issue("t5_store1008", 1'b1, 32'h1008, 32'h1234_5678, 32'h0, 4, 3);
        expect_mem("t6_wb", 1'b1, 32'h1000, 1'b1, 2, 32'h1234_5678);
        expect_mem("t6_rd", 1'b0, 32'h1400, 1'b0, 0, 32'h0);
        issue("t6_load1408", 1'b0, 32'h1408, 32'h0, 32'hC000_1408, 7, 6);
        expect_mem("t6b_rd", 1'b0, 32'h1000, 1'b0, 0, 32'h0);
        issue("t6b_load1008", 1'b0, 32'h1008, 32'h0, 32'h1234_5678, 4, 3);

        // Reset in the second ALLOCATE cycle.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("t7_alloc_enable", {31'b0, mem_enable_o}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_enable", {31'b0, mem_enable_o}, 32'h0);
        chk("t7_rst_stall", {31'b0, cpu_stall_o}, 32'h1);
        chk("t7_rst_cdata", cpu_data_o, 32'h0);
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        expect_mem("t8_rd", 1'b0, 32'h40, 1'b0, 0, 32'h0);
        issue("t8_load40", 1'b0, 32'h40, 32'h0, 32'hA5A5_0000, 4, 3);
        issue("t9_load44", 1'b0, 32'h44, 32'h0, 32'hDEAD_BEEF, 0, 0);

        // Idle cycles with random addresses and a stray ack.
        for (int i = 0; i < 6; i++) begin
            cpu_addr  = $urandom & 32'hFFFF_FFFC;
            stray_ack = (i == 3);
            @(negedge clk);
            chk($sformatf("t10_idle_stall_%0d", i), {31'b0, cpu_stall_o}, 32'h0);
            chk($sformatf("t10_idle_enable_%0d", i), {31'b0, mem_enable_o}, 32'h0);
            @(posedge clk); #1;
        end
        stray_ack = 1'b0;

        // Valid bits unchanged, then back-to-back hits.
        issue("t11_load40", 1'b0, 32'h40, 32'h0, 32'hA5A5_0000, 0, 0);
        expect_mem("t11_rd", 1'b0, 32'h1C0, 1'b0, 0, 32'h0);
        issue("t11_load1c0", 1'b0, 32'h1C0, 32'h0, 32'hC000_01C0, 4, 3);
        issue("t12_load1c4", 1'b0, 32'h1C4, 32'h0, 32'hC000_01C4, 0, 0);
        issue("t12_load1c8", 1'b0, 32'h1C8, 32'h0, 32'hC000_01C8, 0, 0);
        issue("t12_load44", 1'b0, 32'h44, 32'h0, 32'hDEAD_BEEF, 0, 0);

        repeat (3) @(posedge clk);
        chk("end_cpuq_empty", 32'(cpuq.size()), 32'h0);
        chk("end_memq_empty", 32'(memq.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate L1 data cache controller that sits between the CPU MEM stage (Data_Memory port) and a multi-cycle off-chip data memory. It serves one-word hits with no extra latency. On a miss it asserts a stall to the pipeline, writes back the victim line if it is dirty, refills the line, and then completes the held request.

## Interface
Parameters:
- LINES, 16, number of cache lines; index width = log2(LINES).
- LINE_BITS, 256, line size in bits (32 bytes, 8 words).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- cpu_req_i  in  1  MEM-stage access valid (MemRead or MemWrite).
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address, word-aligned.
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data; valid when cpu_req_i=1 and cpu_stall_o=0.
- cpu_stall_o  out  1  freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- mem_enable_o  out  1  memory transaction request.
- mem_write_o  out  1  1 = line write, 0 = line read.
- mem_addr_o  out  32  line address; bits [4:0] are always 0.
- mem_data_o  out  LINE_BITS  write-back line.
- mem_data_i  in  LINE_BITS  refill line; valid in the mem_ack_i cycle.
- mem_ack_i  in  1  one-cycle completion pulse for the current transaction.

## Operation
- Address split, with LINES=16: offset [4:0], word select [4:2], index [8:5], tag [31:9] (23 bits).
- Storage is flop-based, per line: valid bit, dirty bit, tag, and LINE_BITS of data.
- Hit condition: cpu_req_i & valid[idx] & (tag[idx]==addr tag).
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - No request: cpu_stall_o=0 and no state change.
  - Load hit: cpu_data_o = selected word, combinationally.
  - Store hit: the word is merged into the line at the clock edge and dirty is set to 1.
  - Miss: cpu_stall_o=1 in the same cycle.
    - If the victim is valid and dirty, next state is WRITEBACK.
    - Otherwise, next state is ALLOCATE.
- WRITEBACK:
  - Outputs: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, idx, 5'b0}, mem_data_o=victim line.
  - On mem_ack_i, next state is ALLOCATE.
- ALLOCATE:
  - Outputs: mem_enable_o=1, mem_write_o=0, mem_addr_o={req tag, idx, 5'b0}.
  - On mem_ack_i, at that edge: line = mem_data_i, tag = req tag, valid=1, dirty=0. Next state is IDLE.
- After ALLOCATE, the held request is re-evaluated in IDLE and hits. A store merges at that point and sets dirty.
- cpu_stall_o=1 in every cycle where state != IDLE, or where state == IDLE and the request misses.
- cpu_data_o=0 whenever the request does not hit.
- The CPU holds cpu_req_i, cpu_we_i, cpu_addr_i and cpu_data_i stable while cpu_stall_o=1. This is guaranteed by the pipeline freeze.
- mem_addr_o, mem_data_o and mem_write_o are stable throughout a transaction.
- Each mem_ack_i completes exactly one transaction.
- When WRITEBACK transitions to ALLOCATE, mem_enable_o stays high. The read transaction begins in the cycle after the ack.
- mem_ack_i received in IDLE is ignored.

## Timing
- Reset (rst_i=0, asynchronous):
  - State = IDLE; all valid and dirty bits = 0.
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
  - cpu_data_o=0. cpu_stall_o follows the IDLE rule: 1 if cpu_req_i=1 (always a miss), else 0.
- Tag and data contents are not reset.
- Reset mid-transaction: the FSM returns to IDLE and mem_enable_o drops immediately. The memory discards the partial transaction. The line under refill stays invalid.
- Hit: 0 stall cycles.
- Clean miss with memory latency A (cycles mem_enable_o is high, including the ack cycle): stall for A+1 cycles. The request completes in cycle A+1 relative to the miss cycle 0.
- Dirty miss: stall for 1+Aw+Ar cycles.
- A store miss costs the same as a load miss; the merge happens in the completing IDLE cycle.
- Back-to-back hits: one per cycle, no bubbles.

## Test plan
- Read miss after reset:
  - Stimulus: reset, then load 0x0000_0040; memory A=3 returns a line with word0=0xA5A5_0000.
  - Required: cpu_stall_o high for 4 cycles; mem_addr_o=0x40; mem_write_o=0; then cpu_data_o=0xA5A5_0000 with stall low.
- Store hit:
  - Stimulus: store 0xDEADBEEF to 0x44.
  - Required: no stall, no mem_enable_o.
  - Then load 0x44. Required: 0xDEADBEEF in the same cycle, 0 stall.
- Dirty eviction:
  - Stimulus: load 0x0000_0240 (index 2, different tag).
  - Required, first transaction: WRITEBACK with mem_addr_o=0x40, mem_write_o=1, mem_data_o[63:32]=0xDEADBEEF.
  - Required, second transaction: ALLOCATE with mem_addr_o=0x240.
  - Required: total stall 7 cycles at Aw=Ar=3.
- Store miss:
  - Stimulus: store 0x12345678 to 0x1008 (clean victim).
  - Required: a single read at 0x1000, then the merge.
  - Then load 0x1408 (same index). Required: write-back at 0x1000 with mem_data_o[95:64]=0x12345678.
- Reset mid-ALLOCATE:
  - Stimulus: drop rst_i in the 2nd ALLOCATE cycle.
  - Required: mem_enable_o=0 immediately.
  - Then load 0x40 after reset. Required: misses again with a full A+1 stall.
- Idle and stray ack:
  - Stimulus: cpu_req_i=0 with random addresses; pulse mem_ack_i in IDLE.
  - Required: cpu_stall_o=0, mem_enable_o=0, no valid bits change.
